// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ single-beat requesters.
// Sequences SETUP/ACCESS, returns read data / error, and aborts accesses to a hung slave.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  S_IDLE   | no transfer; arbitrate, accept the winner, load APB outputs
//  S_SETUP  | psel=1, penable=0 for exactly one cycle
//  S_ACCESS | psel=penable=1; wait for pready or the timeout, then respond
`timescale 1ns/1ps
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int D_WIDTH = 64,
    parameter int A_WIDTH = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*A_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*D_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*D_WIDTH/8-1:0]   req_strb,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [D_WIDTH-1:0]             rsp_rdata,
    output logic                           rsp_err,
    output logic [A_WIDTH-1:0]             paddr,
    output logic                           psel,
    output logic                           penable,
    output logic                           pwrite,
    output logic [D_WIDTH-1:0]             pwdata,
    output logic [D_WIDTH/8-1:0]           pstrb,
    input  logic                           pready,
    input  logic [D_WIDTH-1:0]             prdata,
    input  logic                           pslverr
);

    localparam int S_WIDTH = D_WIDTH / 8;
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [A_WIDTH-1:0]   paddr_q, paddr_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [D_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [S_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [D_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 gnt_found;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     cand_idx;
    int                   cand;
    logic                 accept;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    assign accept = (state_q == S_IDLE) && gnt_found && !preset;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    paddr_d   = req_addr[gnt_idx*A_WIDTH +: A_WIDTH];
                    pwrite_d  = req_write[gnt_idx];
                    pwdata_d  = req_write[gnt_idx] ? req_wdata[gnt_idx*D_WIDTH +: D_WIDTH] : '0;
                    pstrb_d   = req_write[gnt_idx] ? req_strb[gnt_idx*S_WIDTH +: S_WIDTH] : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    grant_d   = gnt_idx;
                    ptr_d     = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IDX_W'(1);
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = pwrite_q ? '0 : prdata;
                    rsp_err_d            = pslverr;
                    cnt_d                = '0;
                    state_d              = S_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = '0;
                    rsp_err_d            = 1'b1;
                    cnt_d                = '0;
                    state_d              = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign paddr     = paddr_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: table of single transfers plus hand-written
// round-robin, timeout and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_apb_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int D_WIDTH = 64;
    localparam int A_WIDTH = 32;
    localparam int TIMEOUT = 16;
    localparam int S_WIDTH = D_WIDTH / 8;

    logic                         pclk;
    logic                         preset;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           req_write;
    logic [NUM_REQ*A_WIDTH-1:0]   req_addr;
    logic [NUM_REQ*D_WIDTH-1:0]   req_wdata;
    logic [NUM_REQ*S_WIDTH-1:0]   req_strb;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [D_WIDTH-1:0]           rsp_rdata;
    logic                         rsp_err;
    logic [A_WIDTH-1:0]           paddr;
    logic                         psel;
    logic                         penable;
    logic                         pwrite;
    logic [D_WIDTH-1:0]           pwdata;
    logic [S_WIDTH-1:0]           pstrb;
    logic                         pready;
    logic [D_WIDTH-1:0]           prdata;
    logic                         pslverr;

    apb_req_arbiter #(
        .NUM_REQ(NUM_REQ), .D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
        .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Slave: pready after slv_wait extra ACCESS cycles, or never when hung.
    int          slv_wait = 0;
    logic        slv_hang = 1'b0;
    logic        slv_err = 1'b0;
    logic [63:0] slv_prdata = '0;
    int          acc_cnt = 0;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign pready  = psel && penable && !slv_hang && (acc_cnt == slv_wait);
    assign prdata  = slv_prdata;
    assign pslverr = slv_err;

    typedef struct {
        string       name;
        int          req;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        int          wait_st;
        logic [63:0] prdata;
        logic        err;
        logic [63:0] exp_pwdata;
        logic [7:0]  exp_pstrb;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_acc;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [63:0] d, input logic [7:0] s);
        req_write[i] = wr;
        req_addr[i*A_WIDTH +: A_WIDTH]  = a;
        req_wdata[i*D_WIDTH +: D_WIDTH] = d;
        req_strb[i*S_WIDTH +: S_WIDTH]  = s;
    endtask

    function automatic int enc(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Called just after a posedge with the request driven; returns at the accept-cycle negedge.
    task automatic wait_grant(output logic seen, output int lat, output logic [NUM_REQ-1:0] rdy);
        seen = 1'b0;
        lat  = 0;
        rdy  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (req_ready != '0) begin
                seen = 1'b1;
                rdy  = req_ready;
                break;
            end
            lat++;
            @(posedge pclk); #1;
        end
    endtask

    // Called at the SETUP negedge; returns at the first negedge after ACCESS ends.
    task automatic count_access(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                                output int nacc, output logic stable);
        nacc   = 0;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (psel && penable) begin
                nacc++;
                if (paddr !== a || pwdata !== d || pstrb !== s) stable = 1'b0;
            end else begin
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic               seen;
        logic               stable;
        int                 lat;
        int                 nacc;
        logic [NUM_REQ-1:0] rdy;
        logic [NUM_REQ-1:0] exp_oh;
        exp_oh = '0;
        exp_oh[v.req] = 1'b1;
        @(posedge pclk); #1;
        slv_wait   = v.wait_st;
        slv_prdata = v.prdata;
        slv_err    = v.err;
        slv_hang   = 1'b0;
        set_req(v.req, v.wr, v.addr, v.wdata, v.strb);
        req_valid[v.req] = 1'b1;
        wait_grant(seen, lat, rdy);
        check({v.name, "_granted"}, 64'(seen), 64'd1);
        check({v.name, "_grant_lat"}, 64'(lat), 64'd0);
        check({v.name, "_req_ready"}, 64'(rdy), 64'(exp_oh));
        @(posedge pclk); #1;
        req_valid[v.req] = 1'b0;
        @(negedge pclk);
        check({v.name, "_setup_psel"}, 64'(psel), 64'd1);
        check({v.name, "_setup_penable"}, 64'(penable), 64'd0);
        check({v.name, "_paddr"}, 64'(paddr), 64'(v.addr));
        check({v.name, "_pwrite"}, 64'(pwrite), 64'(v.wr));
        check({v.name, "_pwdata"}, pwdata, v.exp_pwdata);
        check({v.name, "_pstrb"}, 64'(pstrb), 64'(v.exp_pstrb));
        count_access(v.addr, v.exp_pwdata, v.exp_pstrb, nacc, stable);
        check({v.name, "_access_cycles"}, 64'(nacc), 64'(v.exp_acc));
        check({v.name, "_bus_stable"}, 64'(stable), 64'd1);
        check({v.name, "_psel_drop"}, 64'(psel), 64'd0);
        check({v.name, "_rsp_valid"}, 64'(rsp_valid), 64'(exp_oh));
        check({v.name, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({v.name, "_rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
        @(negedge pclk);
        check({v.name, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge pclk);
        check({v.name, "_rdata_hold"}, rsp_rdata, v.exp_rdata);
        check({v.name, "_err_hold"}, 64'(rsp_err), 64'(v.exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t               vecs[4];
        vec_t               tv;
        logic               seen;
        logic               stable;
        logic               onehot_ok;
        logic               in_acc;
        int                 lat;
        int                 nacc;
        int                 gcount;
        int                 gnt[5];
        int                 gcyc[5];
        int                 exp_rr[5];
        logic [NUM_REQ-1:0] rdy;

        vecs[0] = '{"w_req2", 2, 1'b1, 32'h100, 64'hDEADBEEF_01234567, 8'hFF, 0, 64'h1234, 1'b0,
                    64'hDEADBEEF_01234567, 8'hFF, 64'h0, 1'b0, 1};
        vecs[1] = '{"r_req1_wait5", 1, 1'b0, 32'h2000_0040, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 5,
                    64'h55AA, 1'b0, 64'h0, 8'h00, 64'h55AA, 1'b0, 6};
        vecs[2] = '{"w_req3_slverr", 3, 1'b1, 32'h44, 64'h1111_2222_3333_4444, 8'h0F, 2,
                    64'h77, 1'b1, 64'h1111_2222_3333_4444, 8'h0F, 64'h0, 1'b1, 3};
        vecs[3] = '{"r_req0_wait1", 0, 1'b0, 32'hFFFF_FFFC, 64'hAAAA, 8'hFF, 1,
                    64'hCAFE_F00D_1234_5678, 1'b0, 64'h0, 8'h00, 64'hCAFE_F00D_1234_5678, 1'b0, 2};
        tv      = '{"w_req0_after_to", 0, 1'b1, 32'h400, 64'h0BAD_F00D, 8'h33, 0, 64'h0, 1'b0,
                    64'h0BAD_F00D, 8'h33, 64'h0, 1'b0, 1};
        exp_rr  = '{0, 1, 2, 3, 0};

        preset    = 1'b1;
        req_valid = '1;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", pwdata, 64'd0);
        check("rst_pstrb", 64'(pstrb), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        @(posedge pclk); #1;
        req_valid = '0;
        @(posedge pclk); #1;
        preset = 1'b0;

        for (int t = 0; t < 4; t++) run_vec(vecs[t]);

        // Round robin from reset with everyone requesting continuously.
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        preset     = 1'b0;
        slv_wait   = 0;
        slv_err    = 1'b0;
        slv_hang   = 1'b0;
        slv_prdata = 64'hABCD;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 32'(i * 16), 64'h0, 8'h0);
        req_valid = '1;
        gcount    = 0;
        onehot_ok = 1'b1;
        for (int c = 0; c < 40 && gcount < 5; c++) begin
            @(negedge pclk);
            if ($countones(req_ready) > 1) onehot_ok = 1'b0;
            if (req_ready != '0) begin
                gnt[gcount]  = enc(req_ready);
                gcyc[gcount] = c;
                gcount++;
            end
            @(posedge pclk); #1;
        end
        req_valid = '0;
        check("rr_grant_count", 64'(gcount), 64'd5);
        for (int k = 0; k < 5; k++) check($sformatf("rr_grant%0d", k), 64'(gnt[k]), 64'(exp_rr[k]));
        check("rr_onehot", 64'(onehot_ok), 64'd1);
        check("rr_spacing", 64'(gcyc[1] - gcyc[0]), 64'd3);
        repeat (6) @(negedge pclk);
        check("rr_last_rdata", rsp_rdata, 64'hABCD);

        // Hung slave: abort after TIMEOUT ACCESS cycles.
        @(posedge pclk); #1;
        slv_hang   = 1'b1;
        slv_prdata = 64'h9999;
        set_req(2, 1'b0, 32'h300, 64'h0, 8'h0);
        req_valid[2] = 1'b1;
        wait_grant(seen, lat, rdy);
        check("to_granted", 64'(seen), 64'd1);
        check("to_req_ready", 64'(rdy), 64'b0100);
        @(posedge pclk); #1;
        req_valid[2] = 1'b0;
        @(negedge pclk);
        count_access(32'h300, 64'h0, 8'h0, nacc, stable);
        check("to_access_cycles", 64'(nacc), 64'(TIMEOUT));
        check("to_psel_drop", 64'(psel), 64'd0);
        check("to_penable_drop", 64'(penable), 64'd0);
        check("to_rsp_valid", 64'(rsp_valid), 64'b0100);
        check("to_rsp_err", 64'(rsp_err), 64'd1);
        check("to_rsp_rdata", rsp_rdata, 64'd0);
        slv_hang = 1'b0;
        run_vec(tv);

        // Reset during ACCESS, then simultaneous requests from 1 and 3.
        @(posedge pclk); #1;
        slv_wait = 10;
        slv_err  = 1'b0;
        set_req(1, 1'b0, 32'h500, 64'h0, 8'h0);
        req_valid[1] = 1'b1;
        wait_grant(seen, lat, rdy);
        check("mr_granted", 64'(seen), 64'd1);
        @(posedge pclk); #1;
        req_valid[1] = 1'b0;
        in_acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (psel && penable) begin
                in_acc = 1'b1;
                break;
            end
        end
        check("mr_in_access", 64'(in_acc), 64'd1);
        @(posedge pclk); #1;
        preset = 1'b1;
        set_req(1, 1'b1, 32'h600, 64'h6, 8'h03);
        set_req(3, 1'b1, 32'h700, 64'h7, 8'h0C);
        req_valid = 4'b1010;
        @(posedge pclk); #1;
        @(negedge pclk);
        check("mr_psel", 64'(psel), 64'd0);
        check("mr_penable", 64'(penable), 64'd0);
        check("mr_paddr", 64'(paddr), 64'd0);
        check("mr_no_rsp", 64'(rsp_valid), 64'd0);
        check("mr_ready_in_reset", 64'(req_ready), 64'd0);
        @(posedge pclk); #1;
        preset   = 1'b0;
        slv_wait = 0;
        gcount   = 0;
        for (int c = 0; c < 20 && gcount < 2; c++) begin
            @(negedge pclk);
            rdy = req_ready;
            if (rdy != '0) begin
                gnt[gcount] = enc(rdy);
                gcount++;
            end
            @(posedge pclk); #1;
            req_valid = req_valid & ~rdy;
        end
        req_valid = '0;
        check("mr_grant_count", 64'(gcount), 64'd2);
        check("mr_first_grant", 64'(gnt[0]), 64'd1);
        check("mr_second_grant", 64'(gnt[1]), 64'd3);
        repeat (5) @(negedge pclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
